// File: rtl/inst_ram_loader.sv
// Boot-time byte-stream loader for the instruction SRAM port 0; holds the core until done.
// Optional INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte check.
module inst_ram_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_csb0,
  output logic              ram_web0,
  output logic [3:0]        ram_wmask0,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic [31:0]       ram_din0,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_bidx;
  logic [31:0]       r_din;
  logic              r_ready;
  logic              r_csb;
  logic              r_web;
  logic [3:0]        r_wmask;
  logic              r_hold;
  logic              r_done;
  logic              r_err;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic        w_acc;
  logic [15:0] w_len;
  logic        w_last;

  assign w_acc  = byte_valid && r_ready;
  assign w_len  = {byte_data, r_len[7:0]};
  assign w_last = ((r_cnt + 16'd1) == r_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_bidx  <= '0;
      r_din   <= '0;
      r_ready <= 1'b0;
      r_csb   <= 1'b1;
      r_web   <= 1'b1;
      r_wmask <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state <= S_LEN_LO;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_bidx  <= '0;
            r_din   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (w_acc) begin
            r_len[7:0] <= byte_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_acc) begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
              r_state <= S_CHK;
`else
              r_state <= S_DONE;
              r_ready <= 1'b0;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
`endif
            end else if (w_len > 16'(MAX_WORDS)) begin
              r_state <= S_ERR;
              r_ready <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_acc) begin
            // Right shift leaves the first byte in [7:0] after four bytes.
            r_din  <= {byte_data, r_din[31:8]};
            r_bidx <= r_bidx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ byte_data;
`endif
            if (r_bidx == 2'd3) begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_csb   <= 1'b0;
              r_web   <= 1'b0;
              r_wmask <= 4'hF;
            end
          end
        end
        S_WRITE: begin
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_wmask <= '0;
          r_cnt   <= r_cnt + 16'd1;
          if (w_last) begin
`ifdef INST_LOADER_CHECKSUM_EN
            r_state <= S_CHK;
            r_ready <= 1'b1;
`else
            r_state <= S_DONE;
            r_hold  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_state <= S_DATA;
            r_ready <= 1'b1;
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_acc) begin
            r_ready <= 1'b0;
            if (byte_data == r_csum) begin
              r_state <= S_DONE;
              r_hold  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_ready;
  assign ram_csb0   = r_csb;
  assign ram_web0   = r_web;
  assign ram_wmask0 = r_wmask;
  assign ram_addr0  = r_addr;
  assign ram_din0   = r_din;
  assign cpu_hold   = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule

// File: tb/tb_inst_ram_loader.sv
// Scoreboard bench for inst_ram_loader: expected SRAM writes are queued by the
// stimulus and popped by a negedge monitor whenever csb0 is low.
module tb_inst_ram_loader;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          ram_csb0;
  logic          ram_web0;
  logic [3:0]    ram_wmask0;
  logic [AW-1:0] ram_addr0;
  logic [31:0]   ram_din0;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  inst_ram_loader #(.ADDR_W(AW), .MAX_WORDS(512)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready),
    .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0),
    .ram_din0(ram_din0), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t exq[$];
  int  total = 0;
  int  bad   = 0;

  logic [7:0] img[$];
  logic [7:0] full[$];
  logic [7:0] cs;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && ram_csb0 === 1'b0) begin
        if (exq.size() == 0) begin
          chk("unexpected_write", {23'd0, ram_addr0}, 32'hFFFF_FFFF);
        end else begin
          e = exq.pop_front();
          chk("wr_addr", {23'd0, ram_addr0}, {23'd0, e.a});
          chk("wr_data", ram_din0, e.d);
          chk("wr_wmask", {28'd0, ram_wmask0}, 32'hF);
          chk("wr_web0", {31'd0, ram_web0}, 32'd0);
          chk("wr_ready", {31'd0, byte_ready}, 32'd0);
        end
      end
    end
  endtask

  task automatic chk_reset_outs(input string t);
    chk({t, "_ready"}, {31'd0, byte_ready}, 0);
    chk({t, "_csb0"}, {31'd0, ram_csb0}, 1);
    chk({t, "_web0"}, {31'd0, ram_web0}, 1);
    chk({t, "_wmask"}, {28'd0, ram_wmask0}, 0);
    chk({t, "_addr"}, {23'd0, ram_addr0}, 0);
    chk({t, "_din"}, ram_din0, 0);
    chk({t, "_hold"}, {31'd0, cpu_hold}, 1);
    chk({t, "_done"}, {31'd0, load_done}, 0);
    chk({t, "_err"}, {31'd0, load_err}, 0);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int tmo;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    tmo = 0;
    while (byte_ready !== 1'b1 && tmo < 40) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 40) chk("byte_timeout", 0, 1);
    else @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int maxgap);
    foreach (s[i]) send(s[i], maxgap > 0 ? $urandom_range(0, maxgap) : 0);
  endtask

  task automatic finish_chk(input string t, input logic exp_done);
    int tmo;
    tmo = 0;
    while (load_done !== 1'b1 && load_err !== 1'b1 && tmo < 200) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 200) chk({t, "_end_timeout"}, 0, 1);
    chk({t, "_done"}, {31'd0, load_done}, {31'd0, exp_done});
    chk({t, "_err"}, {31'd0, load_err}, {31'd0, !exp_done});
    chk({t, "_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
    chk({t, "_pending"}, exq.size(), 0);
  endtask

  task automatic push_img();
    exq.push_back('{a: 9'd0, d: 32'h12345678});
    exq.push_back('{a: 9'd1, d: 32'hDEADBEEF});
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    img = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE};
    cs = 8'h00;
    for (int i = 2; i < img.size(); i++) cs ^= img[i];
    full = img;
`ifdef INST_LOADER_CHECKSUM_EN
    full.push_back(cs);
`endif
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("post_rst");

    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_ready", {31'd0, byte_ready}, 0);
    byte_valid = 1'b0;

    push_img();
    pulse_start();
    chk("start_hold", {31'd0, cpu_hold}, 1);
    chk("start_ready", {31'd0, byte_ready}, 1);
    send_seq(full, 0);
    finish_chk("normal", 1'b1);

    push_img();
    pulse_start();
    chk("restart_clr_done", {31'd0, load_done}, 0);
    send_seq(full, 3);
    finish_chk("bp", 1'b1);

    pulse_start();
    send(8'h01, 0);
    send(8'h02, 0);
    finish_chk("oversize", 1'b0);
    push_img();
    pulse_start();
    chk("restart_clr_err", {31'd0, load_err}, 0);
    send_seq(full, 1);
    finish_chk("after_err", 1'b1);

    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef INST_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    finish_chk("zero_len", 1'b1);

    exq.push_back('{a: 9'd0, d: 32'h12345678});
    pulse_start();
    for (int i = 0; i < 8; i++) send(img[i], 0);
    chk("midword_ready", {31'd0, byte_ready}, 1);
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_pending", exq.size(), 0);
    chk("midrst_idle_done", {31'd0, load_done}, 0);

    push_img();
    pulse_start();
    send_seq(full, 2);
    finish_chk("recover", 1'b1);

`ifdef INST_LOADER_CHECKSUM_EN
    push_img();
    pulse_start();
    send_seq(img, 0);
    send(cs ^ 8'h01, 0);
    finish_chk("bad_csum", 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
